// File: rtl/matrix_job_arbiter_if.sv
// Host job queues, result channel and engine control bundled for matrix_job_arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface matrix_job_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1023:0]    req0_data;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [1023:0]    req1_data;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [511:0]     rsp_data;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;
    logic             eng_rst_n;
    logic             eng_start;
    logic [1023:0]    eng_in_matrix;
    logic             eng_done;
    logic [511:0]     eng_out_matrix;
    logic [15:0]      jobs_done;
    logic [7:0]       timeouts;

    modport slave (
        input  req0_valid, req0_data, req0_tag,
        input  req1_valid, req1_data, req1_tag,
        input  rsp_ready, eng_done, eng_out_matrix,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err, busy,
        output eng_rst_n, eng_start, eng_in_matrix, jobs_done, timeouts
    );

    modport master (
        output req0_valid, req0_data, req0_tag,
        output req1_valid, req1_data, req1_tag,
        output rsp_ready, eng_done, eng_out_matrix,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err, busy,
        input  eng_rst_n, eng_start, eng_in_matrix, jobs_done, timeouts
    );
endinterface

// File: rtl/matrix_job_arbiter.sv
// Round-robin sharing of one 4x4 matrix engine between two requesters:
// accept a job, pulse engine reset, start, wait for done (or time out), return the result.
module matrix_job_arbiter #(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 64,
    parameter int TAG_W      = 4
) (
    input logic                 clk,
    input logic                 reset,
    matrix_job_arbiter_if.slave bus
);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WCW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, RST, START, WAIT, RESP} state_t;

    state_t         state;
    logic           last_grant;
    logic [RCW-1:0] rst_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           grant0, grant1, accept, acc_id;

    // On a tie the requester that did not win last time gets the engine.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end

    assign bus.req0_ready = (state == IDLE) & ~reset & grant0;
    assign bus.req1_ready = (state == IDLE) & ~reset & grant1;
    assign accept = (bus.req0_ready & bus.req0_valid) | (bus.req1_ready & bus.req1_valid);
    assign acc_id = bus.req1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            last_grant        <= 1'b1;
            rst_cnt           <= '0;
            wait_cnt          <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.rsp_id        <= 1'b0;
            bus.rsp_tag       <= '0;
            bus.rsp_err       <= 1'b0;
            bus.busy          <= 1'b0;
            bus.eng_rst_n     <= 1'b0;
            bus.eng_start     <= 1'b0;
            bus.eng_in_matrix <= '0;
            bus.jobs_done     <= '0;
            bus.timeouts      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.eng_in_matrix <= acc_id ? bus.req1_data : bus.req0_data;
                        bus.rsp_tag       <= acc_id ? bus.req1_tag : bus.req0_tag;
                        bus.rsp_id        <= acc_id;
                        last_grant        <= acc_id;
                        rst_cnt           <= RCW'(RST_CYCLES - 1);
                        bus.busy          <= 1'b1;
                        state             <= RST;
                    end
                end
                RST: begin
                    if (rst_cnt == '0) begin
                        bus.eng_rst_n <= 1'b1;
                        bus.eng_start <= 1'b1;
                        state         <= START;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                START: begin
                    bus.eng_start <= 1'b0;
                    wait_cnt      <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Done beats the timeout when both land on the same cycle.
                    if (bus.eng_done) begin
                        bus.rsp_data  <= bus.eng_out_matrix;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.eng_rst_n <= 1'b0;
                        state         <= RESP;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        bus.eng_rst_n <= 1'b0;
                        if (bus.timeouts != 8'hFF) bus.timeouts <= bus.timeouts + 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (!bus.rsp_err) bus.jobs_done <= bus.jobs_done + 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_job_arbiter.sv
// Directed bench for matrix_job_arbiter: a small engine model, a timing-rule reference
// model checked every cycle, and literal expectations per scenario.
module tb_matrix_job_arbiter;
    localparam int R  = 2;
    localparam int TO = 64;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    matrix_job_arbiter_if #(.TAG_W(TW)) bus ();

    matrix_job_arbiter #(.RST_CYCLES(R), .TIMEOUT(TO), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] matmul(input logic [1023:0] d);
        logic [511:0] c;
        logic [31:0]  s;
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int k = 0; k < 4; k++)
                    s = s + d[(i*4+k)*32 +: 32] * d[512 + (k*4+j)*32 +: 32];
                c[(i*4+j)*32 +: 32] = s;
            end
        return c;
    endfunction

    function automatic logic [1023:0] pat(input int s);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = 32'(s * 7 + i * 3 + 1);
        return r;
    endfunction

    // Engine: done goes high eng_delay cycles after start, sticky until eng_rst_n falls.
    int eng_delay = 5;
    int since = 0;
    always @(posedge clk) begin
        if (!bus.eng_rst_n) since <= 0;
        else if (bus.eng_start) since <= 1;
        else if (since != 0 && since < 100000) since <= since + 1;
    end
    assign bus.eng_done       = (eng_delay != 0) && (since >= eng_delay);
    assign bus.eng_out_matrix = matmul(bus.eng_in_matrix);

    // Reference model: one job record plus arrival-time arithmetic.
    bit             m_busy = 0, m_last = 1, m_err = 0, m_id = 0;
    logic [TW-1:0]  m_tag = '0;
    logic [1023:0]  m_in = '0;
    logic [511:0]   m_dat = '0;
    int             m_acc = 0, m_resp = 0;
    logic [15:0]    m_jobs = '0;
    logic [7:0]     m_to = '0;

    int            acc_cyc[$], start_cyc[$], rsp_cyc[$];
    logic          rsp_id_q[$], rsp_err_q[$];
    logic [TW-1:0] rsp_tag_q[$];
    logic [511:0]  rsp_dat_q[$];

    always @(negedge clk) begin
        bit g0, g1, e_r0, e_r1, e_val, e_rstn, e_start, ok;
        if (reset) begin
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_valid", bus.rsp_valid, 0);
            chk("rst_data", bus.rsp_data, 0);
            chk("rst_id", bus.rsp_id, 0);
            chk("rst_tag", bus.rsp_tag, 0);
            chk("rst_err", bus.rsp_err, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_engrstn", bus.eng_rst_n, 0);
            chk("rst_start", bus.eng_start, 0);
            chk("rst_inm", bus.eng_in_matrix[511:0] | bus.eng_in_matrix[1023:512], 0);
            chk("rst_jobs", bus.jobs_done, 0);
            chk("rst_to", bus.timeouts, 0);
            m_busy = 0; m_last = 1; m_jobs = '0; m_to = '0; m_in = '0;
        end else begin
            g0      = bus.req0_valid && (!bus.req1_valid || m_last);
            g1      = bus.req1_valid && (!bus.req0_valid || !m_last);
            e_r0    = !m_busy && g0;
            e_r1    = !m_busy && g1;
            e_rstn  = m_busy && cyc >= m_acc + R + 1 && cyc < m_resp;
            e_start = m_busy && cyc == m_acc + R + 1;
            e_val   = m_busy && cyc >= m_resp;
            chk("ready0", bus.req0_ready, e_r0);
            chk("ready1", bus.req1_ready, e_r1);
            chk("busy", bus.busy, m_busy);
            chk("eng_rst_n", bus.eng_rst_n, e_rstn);
            chk("eng_start", bus.eng_start, e_start);
            chk("rsp_valid", bus.rsp_valid, e_val);
            chk("inm_lo", bus.eng_in_matrix[511:0], m_in[511:0]);
            chk("inm_hi", bus.eng_in_matrix[1023:512], m_in[1023:512]);
            chk("jobs_done", bus.jobs_done, m_jobs);
            chk("timeouts", bus.timeouts, m_to);
            if (e_val) begin
                chk("rsp_data", bus.rsp_data, m_dat);
                chk("rsp_id", bus.rsp_id, m_id);
                chk("rsp_tag", bus.rsp_tag, m_tag);
                chk("rsp_err", bus.rsp_err, m_err);
            end
            // DUT-side event log for the scenario checks
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                acc_cyc.push_back(cyc);
            if (bus.eng_start) start_cyc.push_back(cyc);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cyc.push_back(cyc);
                rsp_id_q.push_back(bus.rsp_id);
                rsp_tag_q.push_back(bus.rsp_tag);
                rsp_err_q.push_back(bus.rsp_err);
                rsp_dat_q.push_back(bus.rsp_data);
            end
            // advance the model to the next cycle
            if (m_busy && cyc + 1 == m_resp && m_err && m_to != 8'hFF) m_to++;
            if ((e_r0 && bus.req0_valid) || (e_r1 && bus.req1_valid)) begin
                m_busy = 1;
                m_id   = e_r1;
                m_last = e_r1;
                m_tag  = e_r1 ? bus.req1_tag : bus.req0_tag;
                m_in   = e_r1 ? bus.req1_data : bus.req0_data;
                m_acc  = cyc;
                ok     = eng_delay != 0 && eng_delay <= TO;
                m_err  = !ok;
                m_resp = cyc + R + 2 + (ok ? eng_delay : TO);
                m_dat  = ok ? matmul(m_in) : '0;
            end else if (e_val && bus.rsp_ready) begin
                if (!m_err) m_jobs++;
                m_busy = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        for (int i = 0; i < 400 && acc_cyc.size() < target; i++) tick(1);
        chk("wait_acc", acc_cyc.size(), target);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 400 && rsp_cyc.size() < target; i++) tick(1);
        chk("wait_rsp", rsp_cyc.size(), target);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] d;
        logic [511:0]  bv, d0;
        int a, r, c0;
        logic [15:0] jd;
        bus.req0_valid = 0; bus.req0_data = '0; bus.req0_tag = '0;
        bus.req1_valid = 0; bus.req1_data = '0; bus.req1_tag = '0;
        bus.rsp_ready  = 1;
        tick(3);
        reset = 0;
        tick(2);

        // single job: identity * (1..16) returns B unchanged
        bv = '0;
        d  = '0;
        for (int i = 0; i < 16; i++) bv[i*32 +: 32] = 32'(i + 1);
        for (int i = 0; i < 4; i++) d[(i*5)*32 +: 32] = 32'd1;
        d[1023:512] = bv;
        eng_delay = 5;
        a = acc_cyc.size(); r = rsp_cyc.size();
        bus.req0_data = d; bus.req0_tag = 4'd3; bus.req0_valid = 1;
        wait_acc(a + 1);
        bus.req0_valid = 0;
        wait_rsp(r + 1);
        chk("t1_id", rsp_id_q[r], 0);
        chk("t1_tag", rsp_tag_q[r], 3);
        chk("t1_err", rsp_err_q[r], 0);
        chk("t1_data", rsp_dat_q[r], bv);
        chk("t1_jobs", bus.jobs_done, 1);
        chk("t1_rst_to_start", start_cyc[start_cyc.size()-1] - acc_cyc[a], 3);
        chk("t1_start_to_rsp", rsp_cyc[r] - start_cyc[start_cyc.size()-1], 6);

        // contention from reset: req0 first, then alternating while both stay valid
        reset = 1;
        bus.req0_data = pat(1); bus.req0_tag = 4'd1; bus.req0_valid = 1;
        bus.req1_data = pat(2); bus.req1_tag = 4'd2; bus.req1_valid = 1;
        eng_delay = 3;
        tick(2);
        a = acc_cyc.size(); r = rsp_cyc.size();
        reset = 0;
        wait_acc(a + 4);
        bus.req0_valid = 0; bus.req1_valid = 0;
        wait_rsp(r + 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_id", rsp_id_q[r+i], i % 2);
            chk("t2_order_tag", rsp_tag_q[r+i], (i % 2) ? 2 : 1);
        end

        // backpressure: 10 cycles of rsp_ready=0 with another request waiting
        bus.rsp_ready = 0;
        eng_delay = 4;
        a = acc_cyc.size(); r = rsp_cyc.size();
        bus.req1_data = pat(3); bus.req1_tag = 4'd5; bus.req1_valid = 1;
        wait_acc(a + 1);
        bus.req1_valid = 0;
        bus.req0_data = pat(4); bus.req0_tag = 4'd6; bus.req0_valid = 1;
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) tick(1);
        chk("t3_valid_rose", bus.rsp_valid, 1);
        c0 = cyc; d0 = bus.rsp_data;
        tick(10);
        chk("t3_hold_valid", bus.rsp_valid, 1);
        chk("t3_hold_data", bus.rsp_data, d0);
        chk("t3_hold_data_lit", d0, matmul(pat(3)));
        bus.rsp_ready = 1;
        wait_rsp(r + 1);
        chk("t3_hs_cycle", rsp_cyc[r] - c0, 10);
        wait_acc(a + 2);
        bus.req0_valid = 0;
        wait_rsp(r + 2);
        chk("t3_second_tag", rsp_tag_q[r+1], 6);

        // timeout: engine never finishes
        eng_delay = 0;
        jd = bus.jobs_done;
        a = acc_cyc.size(); r = rsp_cyc.size();
        bus.req0_data = pat(5); bus.req0_tag = 4'd7; bus.req0_valid = 1;
        wait_acc(a + 1);
        bus.req0_valid = 0;
        wait_rsp(r + 1);
        chk("t4_err", rsp_err_q[r], 1);
        chk("t4_data", rsp_dat_q[r], 0);
        chk("t4_timeouts", bus.timeouts, 1);
        chk("t4_jobs", bus.jobs_done, jd);
        chk("t4_latency", rsp_cyc[r] - start_cyc[start_cyc.size()-1], 65);

        // done exactly on the last wait cycle, then one cycle too late
        eng_delay = 64;
        r = rsp_cyc.size(); a = acc_cyc.size();
        bus.req1_data = pat(6); bus.req1_tag = 4'd8; bus.req1_valid = 1;
        wait_acc(a + 1);
        bus.req1_valid = 0;
        wait_rsp(r + 1);
        chk("t5_err", rsp_err_q[r], 0);
        chk("t5_data", rsp_dat_q[r], matmul(pat(6)));
        chk("t5_latency", rsp_cyc[r] - start_cyc[start_cyc.size()-1], 65);
        eng_delay = 65;
        a = acc_cyc.size();
        bus.req1_tag = 4'd9; bus.req1_valid = 1;
        wait_acc(a + 1);
        bus.req1_valid = 0;
        wait_rsp(r + 2);
        chk("t5b_err", rsp_err_q[r+1], 1);
        chk("t5b_timeouts", bus.timeouts, 2);

        // reset in the middle of WAIT discards the job
        eng_delay = 0;
        a = acc_cyc.size(); r = rsp_cyc.size();
        bus.req0_data = pat(7); bus.req0_tag = 4'd9; bus.req0_valid = 1;
        wait_acc(a + 1);
        bus.req0_valid = 0;
        tick(8);
        reset = 1;
        tick(1);
        reset = 0;
        tick(80);
        chk("t6_no_rsp", rsp_cyc.size(), r);
        chk("t6_jobs", bus.jobs_done, 0);
        chk("t6_to", bus.timeouts, 0);
        chk("t6_busy", bus.busy, 0);
        eng_delay = 2;
        a = acc_cyc.size();
        bus.req0_data = pat(8); bus.req0_tag = 4'd10; bus.req0_valid = 1;
        wait_acc(a + 1);
        bus.req0_valid = 0;
        wait_rsp(r + 1);
        chk("t6_after_id", rsp_id_q[r], 0);
        chk("t6_after_tag", rsp_tag_q[r], 10);
        chk("t6_after_err", rsp_err_q[r], 0);
        chk("t6_after_jobs", bus.jobs_done, 1);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_job_arbiter.md
Name: matrix_job_arbiter

Overview:
- Sequences the 4x4 matrix-multiply engine and shares it between two requesters (req0, req1) using round-robin arbitration.
- Latches one 1024-bit operand job, pulses the engine's active-low reset, and issues a start.
- Waits for the engine's sticky done under a timeout, then returns the 512-bit result with requester id and tag.
- Sits between the host-side job queues and the single matrix engine instance.

Parameters:
RST_CYCLES, 2, cycles eng_rst_n is held low before each job (>=1)
TIMEOUT, 64, max cycles in WAIT before the job is aborted with error (>=2)
TAG_W, 4, width of the per-job tag carried from request to response

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 job valid
req0_ready  out  1  requester 0 job accepted this cycle when valid&ready
req0_data  in  1024  requester 0 operands, [511:0]=A row-major, [1023:512]=B row-major
req0_tag  in  TAG_W  requester 0 job tag
req1_valid  in  1  requester 1 job valid
req1_ready  out  1  requester 1 handshake ready
req1_data  in  1024  requester 1 operands
req1_tag  in  TAG_W  requester 1 job tag
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_data  out  512  16x32-bit result, row-major
rsp_id  out  1  requester that owns the result
rsp_tag  out  TAG_W  tag of the job
rsp_err  out  1  1 = engine timed out, rsp_data is all zero
busy  out  1  high in every state except IDLE
eng_rst_n  out  1  engine reset, active-low
eng_start  out  1  engine start
eng_in_matrix  out  1024  registered operand copy
eng_done  in  1  engine done (sticky until engine reset)
eng_out_matrix  in  512  engine result
jobs_done  out  16  count of error-free responses delivered, wraps
timeouts  out  8  count of timed-out jobs, saturates at 255

Behaviour:
- Reset values: FSM=IDLE, all *_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0, rsp_err=0, busy=0, eng_rst_n=0, eng_start=0, eng_in_matrix=0, jobs_done=0, timeouts=0, last_grant=1 (so req0 wins the first tie).
- States: IDLE, RST, START, WAIT, RESP.
- IDLE, grant:
  - req0 only -> grant req0; req1 only -> grant req1.
  - Both valid -> grant the requester != last_grant.
  - reqN_ready is combinational = (state==IDLE) & granted; at most one ready is high in any cycle.
- IDLE, on handshake:
  - Latch data into eng_in_matrix, plus tag and id; set last_grant=id.
  - Load rst_cnt = RST_CYCLES-1; go to RST.
- RST: eng_rst_n=0; decrement rst_cnt; when 0 -> START.
- START (1 cycle): eng_rst_n=1, eng_start=1; wait_cnt=0; -> WAIT.
- WAIT:
  - eng_rst_n=1, eng_start=0; wait_cnt increments every cycle.
  - eng_done=1: register eng_out_matrix into rsp_data, rsp_err=0 -> RESP.
  - Else if wait_cnt==TIMEOUT-1: rsp_data=0, rsp_err=1, timeouts+=1 (saturating) -> RESP.
  - eng_done wins if both occur in the same cycle.
- RESP:
  - rsp_valid=1 and stays high; rsp_data/id/tag/err are stable until rsp_ready.
  - eng_rst_n=0.
  - On rsp_valid&rsp_ready: if !rsp_err then jobs_done+=1 (wraps 0xFFFF->0); -> IDLE.
  - rsp_valid drops the following cycle.
- eng_rst_n is 0 in IDLE, RST and RESP, and 1 only in START and WAIT. This guarantees the engine's sticky done is cleared before every job.
- eng_in_matrix holds its value from acceptance until the next acceptance.
- No new request is accepted until the current response handshakes; no back-to-back overlap.
- Requests arriving while busy are held by their source (valid stays high); no drop.
- Latency, handshake at cycle T:
  - RST occupies T+1..T+RST_CYCLES.
  - START at T+RST_CYCLES+1.
  - WAIT from T+RST_CYCLES+2.
  - rsp_valid rises the cycle after done is seen.
- Async reset asserted mid-job: the job is discarded, no response is produced, all outputs return to reset values immediately. Counters also clear.
- Any eng_done seen outside WAIT is ignored.

Test Plan:
- Single job, req0: A=identity, B=values 1..16, tag=3, engine done after 5 cycles -> one response: rsp_id=0, rsp_tag=3, rsp_err=0, rsp_data=B; jobs_done=1; eng_rst_n low exactly 2 cycles before eng_start.
- Contention: req0 and req1 both valid from reset with tags 1 and 2 -> order req0 then req1; with both still valid, the next grant alternates (req0, req1, req0...).
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable throughout; req ready stays 0; handshake happens on the first rsp_ready=1 cycle.
- Timeout: engine never asserts done, TIMEOUT=64 -> rsp_valid exactly 64 cycles after entering WAIT, rsp_err=1, rsp_data=0, timeouts=1, jobs_done unchanged.
- Done on final count: eng_done rises at wait_cnt==TIMEOUT-1 -> rsp_err=0 with the captured data.
- Reset mid-WAIT: assert reset for 1 cycle -> rsp_valid never rises, outputs and counters at reset values, next req0 accepted normally.
